imm_field_encoder: RTL and testbench
====================================

Name: imm_field_encoder

Overview:
- Inverse of the datapath's immediate sign-extension stage.
- Takes an instruction format, an opcode, register fields and a 64-bit immediate, and packs them into a 32-bit LEGv8 instruction word (B, CB, D, I formats).
- Checks that the immediate fits its field (signed or zero-extended) and that the opcode is legal, then emits the word through a 2-stage valid/ready pipeline.
- Used by the instruction-memory loader and the test-program generator, so its encodings must round-trip through the decode/extend path.

Parameters:
- CNT_W, 16, width of the saturating error counter

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request this cycle
- fmt  in  2  0=B, 1=CB, 2=D, 3=I
- opcode  in  11  opcode, left-aligned: B uses [10:5], CB uses [10:3], D uses [10:0], I uses [10:1]
- imm  in  64  immediate value
- zext  in  1  1 = unsigned range check, 0 = signed (same meaning as the extender's Ctrl)
- rn  in  5  Rn field (D, I)
- rt  in  5  Rt/Rd field (CB, D, I)
- out_valid  out  1  instruction word valid
- out_ready  in  1  consumer accepts the word
- instr  out  32  encoded instruction
- range_err  out  1  immediate did not fit its field; qualified by out_valid
- op_err  out  1  opcode not in the legal set for fmt; qualified by out_valid
- err_count  out  CNT_W  count of accepted words with any error, saturating

Behaviour:
- Field width W: B=26, CB=19, D=9, I=12.
- Layouts:
  - B: {op[10:5], imm[25:0]}
  - CB: {op[10:3], imm[18:0], rt}
  - D: {op[10:0], imm[8:0], 2'b00, rn, rt}
  - I: {op[10:1], imm[11:0], rn, rt}
- Range check:
  - Signed (zext=0): imm[63:W-1] all equal.
  - Unsigned (zext=1): imm[63:W] all zero.
- Out-of-range words are still emitted with the truncated low W bits and range_err=1. They are never dropped.
- Legal opcode sets:
  - B: 000101, 100101
  - CB: 10110100, 01010100, 10110101
  - D: 00111000000, 00111000010, 01111000000, 01111000010, 10111000000, 10111000100, 11001000000, 11001000010, 11111000000, 11111000010
  - I: 1001000100, 1001001000, 1011000100, 1011001000, 1101000100, 1101001000, 1111000100, 1111001000
  - Any other value sets op_err=1; the word is still emitted.
- Pipeline stage S1: registers the request and computes range_err/op_err.
- Pipeline stage S2: assembles instr and drives the outputs.
- Latency: a word accepted at edge N appears with out_valid at edge N+2 when there is no stall.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational from out_ready)
- Transfer occurs on valid&ready. While out_valid=1 and out_ready=0, instr, range_err and op_err are held stable.
- Order is preserved; there is no loss or duplication. Full throughput is 1 word/cycle.
- Simultaneous accept into S1 and S2 in the same cycle is allowed (normal streaming).
- err_count increments on out_valid&out_ready&(range_err|op_err) and saturates at all-ones.
- Reset values: s1_valid=0, out_valid=0, instr=0, range_err=0, op_err=0, err_count=0.
- Reset asserted mid-stream discards in-flight words. in_ready is 0 during reset.
- While Reset=1, inputs are ignored.

Decomposition:
- Package imm_enc_pkg holds:
  - fmt enum: FMT_B, FMT_CB, FMT_D, FMT_I
  - field-width constants
  - legal-opcode constants
  - function fits(imm, W, zext)
- One sub-module, imm_enc_check, is natural: combinational range and opcode legality check used by S1.

Test Plan:
- I, op=1001000100, imm=5, rn=1, rt=2, zext=0 -> instr=0x91001422 at N+2; range_err=0, op_err=0.
- B, op=000101, imm=-1, zext=0 -> instr=0x17FFFFFF, no error. Same with zext=1 -> range_err=1, err_count=1.
- D, op=11111000010, imm=-256, rn=3, rt=4 -> instr=0xF8500064, no error. Same with imm=-257 -> range_err=1, imm field=9'h0FF.
- CB, op=10110100, zext=1:
  - imm=0x7FFFF, rt=0 -> instr=0xB4FFFFE0, no error.
  - imm=0x80000 -> range_err=1.
  - D with op=0 -> op_err=1. err_count saturation is forced with a reduced CNT_W=2.
- Backpressure: stream words A,B,C,D with out_ready=0 for 4 cycles -> in_ready drops after A,B are held. A stays stable on instr. On release, A,B,C,D emerge in order at 1/cycle with no duplicates.
- Reset mid-stream with 2 words in flight -> next cycle out_valid=0 and err_count=0. The first post-reset request appears after exactly 2 cycles.

Source files
------------

// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the LEGv8 immediate field encoder.
// Field widths, legal opcode sets and the immediate fit test live here.
package imm_enc_pkg;

   typedef enum logic [1:0] {
      FMT_B  = 2'd0,
      FMT_CB = 2'd1,
      FMT_D  = 2'd2,
      FMT_I  = 2'd3
   } fmt_e;

   localparam int W_B  = 26;
   localparam int W_CB = 19;
   localparam int W_D  = 9;
   localparam int W_I  = 12;

   localparam logic [5:0] OP_B  = 6'b000101;
   localparam logic [5:0] OP_BL = 6'b100101;

   localparam logic [7:0] OP_CBZ  = 8'b10110100;
   localparam logic [7:0] OP_BCND = 8'b01010100;
   localparam logic [7:0] OP_CBNZ = 8'b10110101;

   localparam logic [10:0] OP_STURB  = 11'b00111000000;
   localparam logic [10:0] OP_LDURB  = 11'b00111000010;
   localparam logic [10:0] OP_STURH  = 11'b01111000000;
   localparam logic [10:0] OP_LDURH  = 11'b01111000010;
   localparam logic [10:0] OP_STURW  = 11'b10111000000;
   localparam logic [10:0] OP_LDURSW = 11'b10111000100;
   localparam logic [10:0] OP_STXR   = 11'b11001000000;
   localparam logic [10:0] OP_LDXR   = 11'b11001000010;
   localparam logic [10:0] OP_STUR   = 11'b11111000000;
   localparam logic [10:0] OP_LDUR   = 11'b11111000010;

   localparam logic [9:0] OP_ADDI  = 10'b1001000100;
   localparam logic [9:0] OP_ANDI  = 10'b1001001000;
   localparam logic [9:0] OP_ADDIS = 10'b1011000100;
   localparam logic [9:0] OP_ORRI  = 10'b1011001000;
   localparam logic [9:0] OP_SUBI  = 10'b1101000100;
   localparam logic [9:0] OP_EORI  = 10'b1101001000;
   localparam logic [9:0] OP_SUBIS = 10'b1111000100;
   localparam logic [9:0] OP_ANDIS = 10'b1111001000;

   typedef struct packed {
      fmt_e        fmt;
      logic [10:0] op;
      logic [25:0] imm;
      logic [4:0]  rn;
      logic [4:0]  rt;
      logic        range_err;
      logic        op_err;
   } s1_t;

   // Signed: everything above bit w-2 is a copy of the sign bit.
   function automatic logic fits(input logic [63:0] imm,
                                 input int w,
                                 input logic zext);
      logic [63:0] hi;
      if (zext) begin
         hi = imm >> w;
         return hi == '0;
      end
      hi = $signed(imm) >>> (w - 1);
      return (hi == '0) || (hi == '1);
   endfunction

endpackage

// File: rtl/imm_enc_check.sv
// Combinational immediate range and opcode legality check.
// Feeds the S1 register of the encoder.
module imm_enc_check
   import imm_enc_pkg::*;
(
   input  fmt_e        fmt,
   input  logic [10:0] opcode,
   input  logic [63:0] imm,
   input  logic        zext,
   output logic        range_err,
   output logic        op_err
);

   always_comb begin
      range_err = 1'b0;
      op_err    = 1'b1;
      unique case (1'b1)
         (fmt == FMT_B): begin
            range_err = !fits(imm, W_B, zext);
            op_err    = !(opcode[10:5] inside {OP_B, OP_BL});
         end
         (fmt == FMT_CB): begin
            range_err = !fits(imm, W_CB, zext);
            op_err    = !(opcode[10:3] inside
                          {OP_CBZ, OP_BCND, OP_CBNZ});
         end
         (fmt == FMT_D): begin
            range_err = !fits(imm, W_D, zext);
            op_err    = !(opcode inside
                          {OP_STURB, OP_LDURB, OP_STURH,
                           OP_LDURH, OP_STURW, OP_LDURSW,
                           OP_STXR, OP_LDXR, OP_STUR,
                           OP_LDUR});
         end
         (fmt == FMT_I): begin
            range_err = !fits(imm, W_I, zext);
            op_err    = !(opcode[10:1] inside
                          {OP_ADDI, OP_ANDI, OP_ADDIS,
                           OP_ORRI, OP_SUBI, OP_EORI,
                           OP_SUBIS, OP_ANDIS});
         end
         default: begin
            range_err = 1'b0;
            op_err    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_field_encoder.sv
// Packs format, opcode, registers and immediate into a LEGv8 word.
// Two-stage valid/ready pipeline: S1 checks, S2 assembles.
module imm_field_encoder
   import imm_enc_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       fmt,
   input  logic [10:0]      opcode,
   input  logic [63:0]      imm,
   input  logic             zext,
   input  logic [4:0]       rn,
   input  logic [4:0]       rt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      instr,
   output logic             range_err,
   output logic             op_err,
   output logic [CNT_W-1:0] err_count
);

   logic        s1_valid;
   s1_t         s1_q;
   logic        s1_adv;
   logic        s2_adv;
   logic        chk_range;
   logic        chk_op;
   logic [31:0] word;

   assign s2_adv   = !out_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv & !Reset;

   imm_enc_check u_check (
      .fmt       (fmt_e'(fmt)),
      .opcode    (opcode),
      .imm       (imm),
      .zext      (zext),
      .range_err (chk_range),
      .op_err    (chk_op)
   );

   always_ff @(posedge CLK) begin
      if (Reset) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= '{fmt:       fmt_e'(fmt),
                      op:        opcode,
                      imm:       imm[25:0],
                      rn:        rn,
                      rt:        rt,
                      range_err: chk_range,
                      op_err:    chk_op};
         end
      end
   end

   always_comb begin
      word = '0;
      unique case (1'b1)
         (s1_q.fmt == FMT_B):
            word = {s1_q.op[10:5], s1_q.imm[25:0]};
         (s1_q.fmt == FMT_CB):
            word = {s1_q.op[10:3], s1_q.imm[18:0], s1_q.rt};
         (s1_q.fmt == FMT_D):
            word = {s1_q.op, s1_q.imm[8:0], 2'b00,
                    s1_q.rn, s1_q.rt};
         (s1_q.fmt == FMT_I):
            word = {s1_q.op[10:1], s1_q.imm[11:0],
                    s1_q.rn, s1_q.rt};
         default:
            word = '0;
      endcase
   end

   // Output registers only load on a real S1->S2 move, so a stalled
   // word stays put while out_ready is low.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         out_valid <= 1'b0;
         instr     <= '0;
         range_err <= 1'b0;
         op_err    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            instr     <= word;
            range_err <= s1_q.range_err;
            op_err    <= s1_q.op_err;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         err_count <= '0;
      end else if (out_valid && out_ready &&
                   (range_err || op_err) && !(&err_count)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Randomized and directed bench for imm_field_encoder against a
// range/opcode reference model built from plain integer arithmetic.
module tb_imm_field_encoder;

   localparam int CW = 2;

   logic          CLK;
   logic          Reset;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    fmt;
   logic [10:0]   opcode;
   logic [63:0]   imm;
   logic          zext;
   logic [4:0]    rn;
   logic [4:0]    rt;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   instr;
   logic          range_err;
   logic          op_err;
   logic [CW-1:0] err_count;

   imm_field_encoder #(.CNT_W(CW)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fmt       (fmt),
      .opcode    (opcode),
      .imm       (imm),
      .zext      (zext),
      .rn        (rn),
      .rt        (rt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .instr     (instr),
      .range_err (range_err),
      .op_err    (op_err),
      .err_count (err_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] ins;
      bit          re;
      bit          oe;
   } exp_t;

   exp_t        q[$];
   int          n_chk;
   int          n_fail;
   int          exp_cnt;
   bit          hold;
   logic [31:0] hold_ins;
   bit          popped;

   int legal_b[2]  = '{6'b000101, 6'b100101};
   int legal_cb[3] = '{8'b10110100, 8'b01010100, 8'b10110101};
   int legal_d[10] = '{11'b00111000000, 11'b00111000010,
                       11'b01111000000, 11'b01111000010,
                       11'b10111000000, 11'b10111000100,
                       11'b11001000000, 11'b11001000010,
                       11'b11111000000, 11'b11111000010};
   int legal_i[8]  = '{10'b1001000100, 10'b1001001000,
                       10'b1011000100, 10'b1011001000,
                       10'b1101000100, 10'b1101001000,
                       10'b1111000100, 10'b1111001000};

   task automatic expect_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int fwidth(input int f);
      return f == 0 ? 26 : f == 1 ? 19 : f == 2 ? 9 : 12;
   endfunction

   function automatic int obits(input int f);
      return f == 0 ? 6 : f == 1 ? 8 : f == 2 ? 11 : 10;
   endfunction

   function automatic bit is_legal(input int f, input int v);
      bit hit = 0;
      case (f)
         0: foreach (legal_b[k])  if (legal_b[k] == v)  hit = 1;
         1: foreach (legal_cb[k]) if (legal_cb[k] == v) hit = 1;
         2: foreach (legal_d[k])  if (legal_d[k] == v)  hit = 1;
         default: foreach (legal_i[k]) if (legal_i[k] == v) hit = 1;
      endcase
      return hit;
   endfunction

   function automatic exp_t ref_enc(input int f, input logic [10:0] op,
                                    input logic [63:0] im, input bit zx,
                                    input logic [4:0] n, input logic [4:0] t);
      exp_t        e;
      int          w;
      int          opv;
      longint      s;
      longint      lim;
      logic [63:0] modw;
      logic [63:0] field;
      longint      x;
      w     = fwidth(f);
      modw  = 64'd1 << w;
      field = im % modw;
      s     = $signed(im);
      lim   = longint'(1) << (w - 1);
      if (zx) e.re = im >= modw;
      else    e.re = (s < -lim) || (s >= lim);
      opv  = int'(op) / (1 << (11 - obits(f)));
      e.oe = !is_legal(f, opv);
      case (f)
         0: x = longint'(opv) * (1 << 26) + longint'(field);
         1: x = longint'(opv) * (1 << 24) + longint'(field) * 32 + t;
         2: x = longint'(opv) * (1 << 21) + longint'(field) * 4096
                + longint'(n) * 32 + t;
         default: x = longint'(opv) * (1 << 22) + longint'(field) * 1024
                + longint'(n) * 32 + t;
      endcase
      e.ins = 32'(x);
      return e;
   endfunction

   // One clock: drive, observe handshakes just before the edge, advance.
   task automatic cyc(input bit v, input int f, input logic [10:0] op,
                      input logic [63:0] im, input bit zx,
                      input logic [4:0] n, input logic [4:0] t,
                      input bit ordy, output bit acc);
      exp_t e;
      in_valid  = v;
      fmt       = 2'(f);
      opcode    = op;
      imm       = im;
      zext      = zx;
      rn        = n;
      rt        = t;
      out_ready = ordy;
      #1;
      expect_eq("err_count", 64'(err_count), 64'(exp_cnt));
      if (hold) begin
         expect_eq("hold_valid", 64'(out_valid), 64'd1);
         expect_eq("hold_instr", 64'(instr), 64'(hold_ins));
      end
      acc = v && in_ready;
      if (acc) q.push_back(ref_enc(f, op, im, zx, n, t));
      popped = 0;
      if (out_valid && ordy) begin
         popped = 1;
         if (q.size() == 0) begin
            expect_eq("spurious_out", 64'(out_valid), 64'd0);
         end else begin
            e = q.pop_front();
            expect_eq("instr", 64'(instr), 64'(e.ins));
            expect_eq("range_err", 64'(range_err), 64'(e.re));
            expect_eq("op_err", 64'(op_err), 64'(e.oe));
            if ((e.re || e.oe) && exp_cnt < (1 << CW) - 1) exp_cnt++;
         end
      end
      hold     = out_valid && !ordy;
      hold_ins = instr;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic idle(input int ncyc);
      bit a;
      for (int i = 0; i < ncyc; i++) cyc(0, 0, '0, '0, 0, '0, '0, 1, a);
   endtask

   task automatic send(input int f, input logic [10:0] op,
                       input logic [63:0] im, input bit zx,
                       input logic [4:0] n, input logic [4:0] t);
      bit a;
      int tries = 0;
      a = 0;
      while (!a && tries < 20) begin
         cyc(1, f, op, im, zx, n, t, 1, a);
         tries++;
      end
      if (!a) expect_eq("send_timeout", 64'(in_ready), 64'd1);
   endtask

   function automatic logic [10:0] rand_op(input int f);
      int ob;
      int v;
      int lo;
      ob = obits(f);
      if ($urandom_range(0, 1) == 0) begin
         case (f)
            0: v = legal_b[$urandom_range(0, 1)];
            1: v = legal_cb[$urandom_range(0, 2)];
            2: v = legal_d[$urandom_range(0, 9)];
            default: v = legal_i[$urandom_range(0, 7)];
         endcase
      end else begin
         v = int'($urandom_range(0, (1 << ob) - 1));
      end
      lo = int'($urandom_range(0, (1 << (11 - ob)) - 1));
      return 11'(v * (1 << (11 - ob)) + lo);
   endfunction

   function automatic logic [63:0] rand_imm(input int f);
      logic [63:0] r;
      int          w;
      w = fwidth(f);
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: r = 64'($signed(r) >>> $urandom_range(0, 63));
         1: r = (64'd1 << w) - 64'd1;
         2: r = 64'd1 << w;
         3: r = 64'(-(longint'(1) << (w - 1)));
         4: r = 64'(-(longint'(1) << (w - 1)) - 1);
         default: r = 64'($signed(r) >>> (64 - w + $urandom_range(0, 2)));
      endcase
      return r;
   endfunction

   initial begin
      bit          a;
      int          idx;
      int          bnd;
      int          f;
      logic [10:0] bo[4];
      logic [63:0] bi[4];

      n_chk = 0; n_fail = 0; exp_cnt = 0; hold = 0; hold_ins = '0;
      Reset = 1; in_valid = 0; out_ready = 0; fmt = 0; opcode = 0;
      imm = 0; zext = 0; rn = 0; rt = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      in_valid = 1;
      #1;
      expect_eq("rst_out_valid", 64'(out_valid), 64'd0);
      expect_eq("rst_instr", 64'(instr), 64'd0);
      expect_eq("rst_range_err", 64'(range_err), 64'd0);
      expect_eq("rst_op_err", 64'(op_err), 64'd0);
      expect_eq("rst_err_count", 64'(err_count), 64'd0);
      expect_eq("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge CLK);
      Reset = 0;

      // Latency: accepted before edge N, visible after edge N+2.
      cyc(1, 3, 11'b10010001000, 64'd5, 0, 5'd1, 5'd2, 1, a);
      expect_eq("lat_accept", 64'(a), 64'd1);
      in_valid = 0;
      #1;
      expect_eq("lat_n1", 64'(out_valid), 64'd0);
      idle(1);
      expect_eq("lat_n2", 64'(out_valid), 64'd1);
      expect_eq("tp_i_instr", 64'(instr), 64'h91001422);
      idle(2);

      send(0, 11'b00010100000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
      send(0, 11'b00010100000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
      idle(3);
      expect_eq("tp_b_cnt", 64'(err_count), 64'd1);
      send(2, 11'b11111000010, 64'(-256), 0, 5'd3, 5'd4);
      idle(2);
      expect_eq("tp_d_instr", 64'(instr), 64'hF8500064);
      send(2, 11'b11111000010, 64'(-257), 0, 5'd3, 5'd4);
      idle(2);
      expect_eq("tp_d_imm", 64'(instr[20:12]), 64'h0FF);
      expect_eq("tp_d_rerr", 64'(range_err), 64'd1);
      send(1, 11'b10110100000, 64'h7FFFF, 1, 0, 0);
      idle(2);
      expect_eq("tp_cb_instr", 64'(instr), 64'hB4FFFFE0);
      send(1, 11'b10110100000, 64'h80000, 1, 0, 0);
      send(2, 11'd0, 64'd0, 0, 0, 0);
      send(3, 11'd0, 64'd7, 1, 0, 0);
      idle(3);
      expect_eq("tp_sat", 64'(err_count), 64'd3);

      // Backpressure: A,B fill the pipe, C,D wait.
      for (int i = 0; i < 4; i++) begin
         bo[i] = rand_op(3);
         bi[i] = 64'(i + 16);
      end
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         cyc(idx < 4, 3, bo[idx % 4], bi[idx % 4], 0, 5'(c), 5'(idx), 0, a);
         if (a) idx++;
         if (c >= 1) expect_eq("bp_in_ready", 64'(in_ready), 64'd0);
      end
      expect_eq("bp_accepted", 64'(idx), 64'd2);
      for (int c = 0; c < 4; c++) begin
         cyc(idx < 4, 3, bo[idx % 4], bi[idx % 4], 0, 5'd9, 5'(idx), 1, a);
         if (a) idx++;
         expect_eq("bp_thru", 64'(popped), 64'd1);
      end
      expect_eq("bp_drained", 64'(q.size()), 64'd0);

      // Reset with two words in flight.
      send(2, 11'b00111000000, 64'd1, 0, 1, 1);
      send(2, 11'b00111000000, 64'd2, 0, 1, 1);
      Reset = 1;
      in_valid = 1;
      #1;
      expect_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
      @(posedge CLK);
      @(negedge CLK);
      Reset = 0;
      q.delete();
      exp_cnt = 0;
      hold = 0;
      in_valid = 0;
      #1;
      expect_eq("post_rst_valid", 64'(out_valid), 64'd0);
      expect_eq("post_rst_cnt", 64'(err_count), 64'd0);
      cyc(1, 1, 11'b01010100000, 64'd3, 0, 0, 5'd7, 1, a);
      expect_eq("post_rst_accept", 64'(a), 64'd1);
      in_valid = 0;
      #1;
      expect_eq("post_rst_n1", 64'(out_valid), 64'd0);
      idle(1);
      expect_eq("post_rst_n2", 64'(out_valid), 64'd1);
      idle(2);

      for (int i = 0; i < 500; i++) begin
         f = int'($urandom_range(0, 3));
         cyc($urandom_range(0, 3) != 0, f, rand_op(f), rand_imm(f),
             $urandom_range(0, 1) == 1, 5'($urandom), 5'($urandom),
             $urandom_range(0, 3) != 0, a);
      end
      bnd = 0;
      while (q.size() != 0 && bnd < 20) begin
         idle(1);
         bnd++;
      end
      expect_eq("final_drain", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
